// File: rtl/fdiv_iter.sv
// Multi-cycle binary32 divider (round-to-nearest-even). PREP normalises operands and
// resolves specials, ITER produces one restoring quotient bit per cycle, ROUND packs.
module fdiv_iter #(
  parameter int ITER = 26
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [10:0] exp_q, exp_d;
  logic [ITER-1:0]    rem_q, rem_d, quo_q, quo_d;
  logic [23:0]        div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         flags_q, flags_d;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd0;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  // Operand unpack, subnormal normalisation and special-case decode
  logic               a_sub, b_sub, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               special;
  logic [4:0]         lz_a, lz_b, spec_flags;
  logic [23:0]        ma_n, mb_n;
  logic signed [10:0] ea_n, eb_n, e_div;
  logic [31:0]        spec_res;

  always_comb begin
    a_sub  = (a_q[30:23] == 8'd0);
    b_sub  = (b_q[30:23] == 8'd0);
    a_zero = a_sub && (a_q[22:0] == 23'd0);
    b_zero = b_sub && (b_q[22:0] == 23'd0);
    a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    lz_a   = a_sub ? lzc24({1'b0, a_q[22:0]}) : 5'd0;
    lz_b   = b_sub ? lzc24({1'b0, b_q[22:0]}) : 5'd0;
    ma_n   = {!a_sub, a_q[22:0]} << lz_a;
    mb_n   = {!b_sub, b_q[22:0]} << lz_b;
    ea_n   = a_sub ? 11'sd1 - $signed({6'd0, lz_a}) : $signed({3'd0, a_q[30:23]});
    eb_n   = b_sub ? 11'sd1 - $signed({6'd0, lz_b}) : $signed({3'd0, b_q[30:23]});
    e_div  = ea_n - eb_n + 11'sd127;

    special    = 1'b1;
    spec_res   = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
    spec_flags = 5'd0;
    if (a_nan || b_nan) begin
      spec_res   = 32'h7FC0_0000;
      spec_flags = {(a_nan && !a_q[22]) || (b_nan && !b_q[22]), 4'd0};
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = 32'h7FC0_0000;
      spec_flags = 5'b10000;
    end else if (b_zero) begin
      spec_flags = 5'b01000;
    end else if (a_inf) begin
      spec_flags = 5'd0;
    end else if (a_zero || b_inf) begin
      spec_res   = {a_q[31] ^ b_q[31], 31'd0};
    end else begin
      special    = 1'b0;
    end
  end

  // Denormalise tiny results, then RNE; the hidden bit is folded into the exponent field
  logic [10:0]     shamt;
  logic [ITER-1:0] q_sh, q_mask;
  logic [7:0]      e_pre;
  logic            stk, rnd_up, nx, ovf;
  logic [31:0]     sum, rnd_res;
  logic [4:0]      rnd_flags;

  always_comb begin
    shamt  = 11'(11'sd1 - exp_q);
    q_sh   = quo_q;
    q_mask = '0;
    stk    = (rem_q != '0);
    e_pre  = exp_q[7:0] - 8'd1;
    ovf    = (exp_q >= 11'sd255);
    if (exp_q <= 11'sd0) begin
      e_pre = 8'd0;
      if (shamt >= 11'(ITER)) begin
        stk  = stk || (quo_q != '0);
        q_sh = '0;
      end else begin
        q_mask = (ITER'(1) << shamt) - ITER'(1);
        stk    = stk || ((quo_q & q_mask) != '0);
        q_sh   = quo_q >> shamt;
      end
    end
    rnd_up = q_sh[1] && (q_sh[0] || stk || q_sh[2]);
    nx     = q_sh[1] || q_sh[0] || stk;
    sum    = {1'b0, e_pre, 23'd0} + {8'd0, q_sh[25:2]} + {31'd0, rnd_up};
    ovf    = ovf || (sum[30:23] == 8'hFF);
    if (ovf) begin
      rnd_res   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = 5'b00101;
    end else begin
      rnd_res   = {sign_q, sum[30:0]};
      rnd_flags = {3'b000, (sum[30:23] == 8'd0) && nx, nx};
    end
  end

  logic [ITER:0] diff;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flags_d = flags_q;
    diff    = {1'b0, rem_q} - {{(ITER-23){1'b0}}, div_q};
    case (state_q)
      S_IDLE: if (start_i && !flush_i) begin
        a_d     = a_i;
        b_d     = b_i;
        busy_d  = 1'b1;
        state_d = S_PREP;
      end
      S_PREP: if (flush_i) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else if (special) begin
        res_d   = spec_res;
        flags_d = spec_flags;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        sign_d  = a_q[31] ^ b_q[31];
        exp_d   = (ma_n < mb_n) ? e_div - 11'sd1 : e_div;
        rem_d   = (ma_n < mb_n) ? {1'b0, ma_n, 1'b0} : {2'b00, ma_n};
        div_d   = mb_n;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: if (flush_i) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        quo_d = {quo_q[ITER-2:0], !diff[ITER]};
        rem_d = (diff[ITER] ? rem_q : diff[ITER-1:0]) << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_ROUND;
      end
      S_ROUND: if (flush_i) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
  assign flags_o  = flags_q;

endmodule
